clkdiv_ratio_ctrl: RTL and testbench
====================================

// Module: clkdiv_ratio_ctrl
// PURPOSE
//   Run-time controller for the 4-bit ripple-ratio clock divider.
//   - Owns the divide counter and selects one of the /2, /4, /8 or /16 taps.
//   - Accepts ratio-change requests over a req/ack handshake.
//   - Applies each change only at the counter wrap boundary, so div_out never
//     shows a runt pulse or a shortened period.
//   - Sits between the config/register interface and logic that needs one
//     selectable slow enable/clock.
// PARAMETERS
//   CNT_W    4     counter width; number of taps = CNT_W; max ratio 2**CNT_W
//   SEL_W    2     select width; must equal clog2(CNT_W)
//   DEF_SEL  0     tap selected out of reset (0 = /2)
// PORTS
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   en        in   1      count enable; counter and FSM timing freeze when low
//   sel_req   in   1      ratio-change request, level, held until sel_ack
//   sel_in    in   SEL_W  requested tap: k selects divide by 2**(k+1)
//   sel_ack   out  1      one-cycle pulse: request accepted and applied
//   busy      out  1      a request is pending, waiting for the boundary
//   cur_sel   out  SEL_W  tap currently driving div_out
//   cnt       out  CNT_W  divide counter value
//   div_out   out  1      registered divided output = cnt[cur_sel]
//   tick      out  1      one-cycle pulse, coincident with div_out rising
// BEHAVIOUR
//   Reset values: cnt=0, cur_sel=DEF_SEL, div_out=0, tick=0, sel_ack=0, busy=0,
//   state=IDLE. Any pending request is discarded.
//   Counter: when en=1, cnt increments modulo 2**CNT_W (all-ones -> 0).
//   When en=0, cnt holds.
//   div_out and tick are registered from next-state values: both take effect
//   in the same cycle as the cnt update, adding 0 cycles of latency vs cnt.
//   Boundary event: en=1 and cnt=all-ones. Every tap falls 1->0 here, so
//   changing the tap here is glitch-free.
//   FSM states:
//     IDLE
//       sel_req=1 and sel_in=cur_sel: go to ACK; no wait.
//       sel_req=1 and sel_in!=cur_sel: latch sel_in into pend_sel, set busy,
//       go to WAIT_BND.
//     WAIT_BND
//       On the boundary event: cur_sel<=pend_sel in the same edge as cnt->0,
//       clear busy, go to ACK.
//       sel_in changes while here are ignored; pend_sel is already latched.
//     ACK
//       sel_ack=1 for exactly this cycle, then return to IDLE.
//       The requester drops sel_req on seeing sel_ack. A sel_req still high in
//       the IDLE cycle after ACK is treated as a new request.
//   Worst-case latency, sel_req to sel_ack: 2**CNT_W+1 enabled cycles. The
//   same-tap request acks in 1 cycle.
//   en=0 in WAIT_BND: the wait simply extends; busy stays high.
//   Asserting rst_n low mid-wait: the request is lost and no ack is issued.
//   The requester must re-issue it after reset.
//   sel_in values >= CNT_W (only possible if CNT_W < 2**SEL_W): clamp to
//   CNT_W-1.
//   tick=1 iff next div_out=1 and current div_out=0.
// STRUCTURE
//   Shared package clkdiv_pkg holds:
//     - localparams for the tap encodings: SEL_DIV2=0, SEL_DIV4=1,
//       SEL_DIV8=2, SEL_DIV16=3;
//     - the FSM state encoding: IDLE=2'd0, WAIT_BND=2'd1, ACK=2'd2.
//   One sub-module, clkdiv_counter: cnt register, en, wrap flag output.
//   The FSM, tap mux, and div_out/tick registers stay in this module.
// TESTING
//   1 Reset release, en=1, no requests
//     -> div_out toggles every cycle (/2); tick every 2nd cycle; cnt 0..15
//        wraps to 0.
//   2 At cnt=3 request sel_in=3
//     -> busy=1 for 12 cycles; at cnt 15->0 cur_sel=3; sel_ack pulses the
//        next cycle.
//     -> Then div_out is high for 8 cycles and low for 8 cycles; no pulse
//        shorter than 1 cycle.
//   3 Request sel_in equal to cur_sel
//     -> sel_ack pulses 1 cycle after sel_req; busy stays 0; cnt unaffected.
//   4 Request issued at cnt=5, then en=0 for 20 cycles, then en=1
//     -> cnt holds at its value; busy stays 1.
//     -> The switch occurs at the first enabled 15->0 wrap; exactly one
//        sel_ack.
//   5 rst_n asserted low while in WAIT_BND
//     -> sel_ack never asserts; cur_sel=DEF_SEL.
//     -> All outputs return to reset values immediately (asynchronously).
//   6 sel_in changed from 2 to 1 while busy
//     -> the tap applied is still 2; one sel_ack.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared encodings for the ratio-select clock divider: tap selects and FSM states.
package clkdiv_pkg;

  localparam logic [1:0] SEL_DIV2  = 2'd0;
  localparam logic [1:0] SEL_DIV4  = 2'd1;
  localparam logic [1:0] SEL_DIV8  = 2'd2;
  localparam logic [1:0] SEL_DIV16 = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BND = 2'd1,
    ACK      = 2'd2
  } state_t;

endpackage

// File: rtl/clkdiv_counter.sv
// Free-running divide counter; exposes next value and the all-ones wrap event.
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             wrap
);

  assign cnt_nxt = en ? cnt + CNT_W'(1) : cnt;
  assign wrap    = en & (&cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/clkdiv_ratio_ctrl.sv
// Run-time ratio controller: tap changes are deferred to the counter wrap so
// div_out never produces a runt pulse or a shortened period.
module clkdiv_ratio_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int SEL_W   = 2,
  parameter int DEF_SEL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel_req,
  input  logic [SEL_W-1:0] sel_in,
  output logic             sel_ack,
  output logic             busy,
  output logic [SEL_W-1:0] cur_sel,
  output logic [CNT_W-1:0] cnt,
  output logic             div_out,
  output logic             tick
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] pend_sel, pend_nxt, sel_nxt, sel_cl;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap, div_nxt;

  clkdiv_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cnt     (cnt),
    .cnt_nxt (cnt_nxt),
    .wrap    (wrap)
  );

  // Out-of-range selects only exist when the select field has spare codes.
  generate
    if (CNT_W < 2**SEL_W) begin : g_clamp
      assign sel_cl = (sel_in > SEL_W'(CNT_W-1)) ? SEL_W'(CNT_W-1) : sel_in;
    end else begin : g_noclamp
      assign sel_cl = sel_in;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_sel;
    sel_nxt   = cur_sel;
    case (state)
      IDLE: begin
        if (sel_req) begin
          if (sel_cl == cur_sel) begin
            state_nxt = ACK;
          end else begin
            pend_nxt  = sel_cl;
            state_nxt = WAIT_BND;
          end
        end
      end
      WAIT_BND: begin
        // every tap falls 1->0 at the wrap, so the switch is glitch-free here
        if (wrap) begin
          sel_nxt   = pend_sel;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign div_nxt = cnt_nxt[sel_nxt];
  assign busy    = (state == WAIT_BND);
  assign sel_ack = (state == ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend_sel <= SEL_W'(DEF_SEL);
      cur_sel  <= SEL_W'(DEF_SEL);
      div_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_sel <= pend_nxt;
      cur_sel  <= sel_nxt;
      div_out  <= div_nxt;
      tick     <= div_nxt & ~div_out;
    end
  end

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Directed bench for clkdiv_ratio_ctrl; acks are scored against a queue of
// expected (tap, cnt) pairs pushed when each request is issued.
module tb_clkdiv_ratio_ctrl;
  import clkdiv_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, sel_req;
  logic [1:0] sel_in;
  logic       sel_ack, busy, div_out, tick;
  logic [1:0] cur_sel;
  logic [3:0] cnt;

  int total = 0;
  int bad   = 0;
  int ack_n = 0;
  logic [3:0] ecnt = '0;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  clkdiv_ratio_ctrl #(.CNT_W(4), .SEL_W(2), .DEF_SEL(0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sel_req (sel_req),
    .sel_in  (sel_in),
    .sel_ack (sel_ack),
    .busy    (busy),
    .cur_sel (cur_sel),
    .cnt     (cnt),
    .div_out (div_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; keeps the reference count in step with the enable seen at the edge.
  task automatic step();
    logic e;
    e = en;
    @(posedge clk);
    #1;
    if (e) ecnt = ecnt + 4'd1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cnt"},  32'(cnt), 0);
    chk({tag, "_sel"},  32'(cur_sel), 32'(SEL_DIV2));
    chk({tag, "_div"},  32'(div_out), 0);
    chk({tag, "_tick"}, 32'(tick), 0);
    chk({tag, "_ack"},  32'(sel_ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic wait_ack(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (sel_ack === 1'b1) seen = 1;
    end
    sel_req = 1'b0;
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sel_ack === 1'b1) begin
      exp_t e;
      ack_n++;
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_cur_sel", 32'(cur_sel), 32'(e.sel));
        chk("ack_cnt", 32'(cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    int busy_n, acks0;
    rst_n = 1'b0; en = 1'b0; sel_req = 1'b0; sel_in = 2'd0;
    #12;
    check_reset_vals("rst");

    // 1: /2 out of reset, wrap 15->0
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      chk("t1_cnt",  32'(cnt), 32'(ecnt));
      chk("t1_div",  32'(div_out), 32'(ecnt[0]));
      chk("t1_tick", 32'(tick), 32'(ecnt[0]));
    end

    // 2: request /16 at cnt=3
    for (int i = 0; i < 20 && ecnt != 4'd3; i++) step();
    chk("t2_at3", 32'(cnt), 3);
    sel_req = 1'b1; sel_in = SEL_DIV16;
    exp_q.push_back('{sel: SEL_DIV16, cnt: 4'd0});
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sel_ack === 1'b1) break;
      if (busy === 1'b1) busy_n++;
    end
    sel_req = 1'b0;
    chk("t2_ack", 32'(sel_ack), 1);
    chk("t2_busy_cycles", 32'(busy_n), 12);
    for (int i = 1; i <= 32; i++) begin
      step();
      chk("t2_div",  32'(div_out), 32'((i % 16) >= 8));
      chk("t2_tick", 32'(tick), 32'((i % 16) == 8));
    end

    // 3: same-tap request acks next cycle, no wait
    sel_req = 1'b1; sel_in = SEL_DIV16;
    exp_q.push_back('{sel: SEL_DIV16, cnt: ecnt + 4'd1});
    step();
    sel_req = 1'b0;
    chk("t3_ack",  32'(sel_ack), 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_cnt",  32'(cnt), 32'(ecnt));
    step();
    chk("t3_ack_drop", 32'(sel_ack), 0);

    // 4: request at cnt=5, then stall 20 cycles
    for (int i = 0; i < 20 && ecnt != 4'd5; i++) step();
    chk("t4_at5", 32'(cnt), 5);
    sel_req = 1'b1; sel_in = SEL_DIV4;
    exp_q.push_back('{sel: SEL_DIV4, cnt: 4'd0});
    acks0 = ack_n;
    step();
    en = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("t4_hold_cnt",  32'(cnt), 6);
    chk("t4_hold_busy", 32'(busy), 1);
    chk("t4_hold_sel",  32'(cur_sel), 32'(SEL_DIV16));
    en = 1'b1;
    wait_ack("t4");
    for (int i = 0; i < 4; i++) step();
    chk("t4_one_ack", 32'(ack_n - acks0), 1);

    // 6: sel_in changes while busy; latched tap wins
    sel_req = 1'b1; sel_in = SEL_DIV8;
    exp_q.push_back('{sel: SEL_DIV8, cnt: 4'd0});
    acks0 = ack_n;
    step();
    chk("t6_busy", 32'(busy), 1);
    sel_in = SEL_DIV4;
    wait_ack("t6");
    for (int i = 0; i < 4; i++) step();
    chk("t6_one_ack", 32'(ack_n - acks0), 1);
    chk("t6_sel", 32'(cur_sel), 32'(SEL_DIV8));

    // 5: async reset mid-wait drops the request
    sel_req = 1'b1; sel_in = SEL_DIV2;
    acks0 = ack_n;
    step();
    chk("t5_busy", 32'(busy), 1);
    sel_req = 1'b0;
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    ecnt = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("t5_no_ack", 32'(ack_n - acks0), 0);
    chk("t5_sel", 32'(cur_sel), 32'(SEL_DIV2));
    chk("t5_cnt", 32'(cnt), 32'(ecnt));
    chk("t5_queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
